// File: rtl/hdmi_i2c_config_sequencer.sv
// Walks an external register-write table and issues one 3-byte I2C write per entry
// (address, register, value) through i2c_master_top, retrying NACKed or hung writes.
module hdmi_i2c_config_sequencer #(
  parameter int         NUM_WRITES  = 32,
  parameter logic [6:0] SLAVE_ADDR  = 7'h39,
  parameter int         MAX_RETRIES = 3,
  parameter int         TIMEOUT     = 200,
  parameter int         STOP_GAP    = 8
) (
  input  logic                          clk_50k,
  input  logic                          reset_n,
  input  logic                          go,
  output logic                          busy,
  output logic                          cfg_done,
  output logic                          cfg_error,
  output logic [$clog2(NUM_WRITES)-1:0] err_index,
  output logic [$clog2(NUM_WRITES)-1:0] cfg_index,
  input  logic [7:0]                    cfg_reg,
  input  logic [7:0]                    cfg_val,
  output logic                          i2c_reset,
  output logic                          i2c_start,
  output logic [6:0]                    i2c_slave_address,
  output logic                          i2c_read_write,
  output logic [7:0]                    i2c_data,
  output logic [2:0]                    i2c_byte_num,
  input  logic                          i2c_done,
  input  logic                          i2c_fail
);

  localparam int IDX_W = $clog2(NUM_WRITES);
  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (STOP_GAP > 2) ? $clog2(STOP_GAP + 1) : 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WRITES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STOP_GAP - 1);
  localparam logic [GAP_W-1:0] RCV_LAST = GAP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_REG,
    S_WAIT_VAL,
    S_GAP,
    S_ADVANCE,
    S_RECOVER
  } state_t;

  state_t             r_state, w_state_next;
  logic               r_busy, w_busy_next;
  logic               r_done, w_done_next;
  logic               r_error, w_error_next;
  logic [IDX_W-1:0]   r_err_index, w_err_index_next;
  logic [IDX_W-1:0]   r_index, w_index_next;
  logic               r_byte_sel, w_byte_sel_next;
  logic [RTY_W-1:0]   r_retry, w_retry_next;
  logic [TMO_W-1:0]   r_tmo, w_tmo_next;
  logic [GAP_W-1:0]   r_gap, w_gap_next;
  logic [1:0]         r_rst_hold;
  logic               w_start;
  logic [TMO_W-1:0]   w_tmo_inc;
  logic               w_tmo_hit;

  assign w_tmo_inc = (r_tmo == {TMO_W{1'b1}}) ? r_tmo : r_tmo + 1'b1;
  assign w_tmo_hit = (r_tmo >= TMO_LAST);

  always_ff @(posedge clk_50k) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_index <= '0;
      r_index     <= '0;
      r_byte_sel  <= 1'b0;
      r_retry     <= '0;
      r_tmo       <= '0;
      r_gap       <= '0;
      r_rst_hold  <= 2'd2;
    end else begin
      r_state     <= w_state_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_error     <= w_error_next;
      r_err_index <= w_err_index_next;
      r_index     <= w_index_next;
      r_byte_sel  <= w_byte_sel_next;
      r_retry     <= w_retry_next;
      r_tmo       <= w_tmo_next;
      r_gap       <= w_gap_next;
      if (r_rst_hold != 2'd0) begin
        r_rst_hold <= r_rst_hold - 2'd1;
      end
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_busy_next      = r_busy;
    w_done_next      = r_done;
    w_error_next     = r_error;
    w_err_index_next = r_err_index;
    w_index_next     = r_index;
    w_byte_sel_next  = r_byte_sel;
    w_retry_next     = r_retry;
    w_tmo_next       = r_tmo;
    w_gap_next       = r_gap;
    w_start          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (go) begin
          w_done_next  = 1'b0;
          w_error_next = 1'b0;
          w_retry_next = '0;
          w_index_next = '0;
          w_busy_next  = 1'b1;
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_byte_sel_next = 1'b0;
        w_tmo_next      = '0;
        w_state_next    = S_START;
      end
      S_START: begin
        w_start      = 1'b1;
        w_state_next = S_WAIT_REG;
      end
      // A NACK outranks a done in the same cycle; a done outranks an expiring timeout.
      S_WAIT_REG: begin
        if (i2c_fail) begin
          w_gap_next   = '0;
          w_state_next = S_RECOVER;
        end else if (i2c_done) begin
          w_byte_sel_next = 1'b1;
          w_tmo_next      = '0;
          w_state_next    = S_WAIT_VAL;
        end else if (w_tmo_hit) begin
          w_gap_next   = '0;
          w_state_next = S_RECOVER;
        end else begin
          w_tmo_next = w_tmo_inc;
        end
      end
      S_WAIT_VAL: begin
        if (i2c_fail) begin
          w_gap_next   = '0;
          w_state_next = S_RECOVER;
        end else if (i2c_done) begin
          w_gap_next   = '0;
          w_state_next = S_GAP;
        end else if (w_tmo_hit) begin
          w_gap_next   = '0;
          w_state_next = S_RECOVER;
        end else begin
          w_tmo_next = w_tmo_inc;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_next = S_ADVANCE;
        end else begin
          w_gap_next = r_gap + 1'b1;
        end
      end
      S_ADVANCE: begin
        if (r_index == LAST_IDX) begin
          w_done_next  = 1'b1;
          w_busy_next  = 1'b0;
          w_state_next = S_IDLE;
        end else begin
          w_index_next = r_index + 1'b1;
          w_retry_next = '0;
          w_state_next = S_LOAD;
        end
      end
      // Two cycles of master reset, which also drops its sticky fail flag.
      S_RECOVER: begin
        if (r_gap == RCV_LAST) begin
          if (r_retry < RTY_MAX) begin
            w_retry_next = r_retry + 1'b1;
            w_state_next = S_LOAD;
          end else begin
            w_error_next     = 1'b1;
            w_err_index_next = r_index;
            w_busy_next      = 1'b0;
            w_state_next     = S_IDLE;
          end
        end else begin
          w_gap_next = r_gap + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign busy              = r_busy;
  assign cfg_done          = r_done;
  assign cfg_error         = r_error;
  assign err_index         = r_err_index;
  assign cfg_index         = r_index;
  assign i2c_start         = w_start;
  assign i2c_reset         = ~reset_n | (r_rst_hold != 2'd0) | (r_state == S_RECOVER);
  assign i2c_slave_address = SLAVE_ADDR;
  assign i2c_read_write    = 1'b0;
  assign i2c_byte_num      = 3'd2;
  // Data bus is parked at zero while idle so it reads cleanly out of reset.
  assign i2c_data          = (r_state == S_IDLE) ? 8'h00 : (r_byte_sel ? cfg_val : cfg_reg);

endmodule

// File: doc/hdmi_i2c_config_sequencer.md
Name: hdmi_i2c_config_sequencer

Overview:
- Walks a register-write table for the HDMI transmitter and issues one I2C write per entry through i2c_master_top.
- Each entry is sent as one transaction: slave address, register address byte, value byte.
- Handles the master's done pulses and its sticky fail flag.
- Retries failed or hung writes, then reports overall completion or error to the top-level bring-up logic.

Parameters:
- NUM_WRITES, 32, entries in the table; indices 0..NUM_WRITES-1.
- SLAVE_ADDR, 7'h39, 7-bit I2C address of the transmitter.
- MAX_RETRIES, 3, retries per entry after the first attempt fails.
- TIMEOUT, 200, clk_50k cycles allowed between start and each done pulse.
- STOP_GAP, 8, idle cycles after the final done so the master reaches IDLE before the next start.

Ports:
- clk_50k  in  1  system clock; same 50 kHz domain as i2c_master_top.
- reset_n  in  1  synchronous, active-low reset.
- go  in  1  one-cycle pulse that starts a full table pass. Ignored while busy.
- busy  out  1  high from the cycle after go until cfg_done or cfg_error is set.
- cfg_done  out  1  sticky; the pass completed with all writes acked.
- cfg_error  out  1  sticky; an entry exhausted its retries.
- err_index  out  $clog2(NUM_WRITES)  index of the failing entry; valid when cfg_error=1.
- cfg_index  out  $clog2(NUM_WRITES)  table address presented to the external ROM.
- cfg_reg  in  8  register address at cfg_index; combinational ROM read.
- cfg_val  in  8  register value at cfg_index.
- i2c_reset  out  1  active-high reset to the master.
- i2c_start  out  1  start request to the master.
- i2c_slave_address  out  7  always SLAVE_ADDR.
- i2c_read_write  out  1  always 0 (write).
- i2c_data  out  8  byte to transmit.
- i2c_byte_num  out  3  always 3'd2.
- i2c_done  in  1  master's pulse marking the end of a data byte.
- i2c_fail  in  1  master's sticky NACK flag.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE; busy=0, cfg_done=0, cfg_error=0, err_index=0, cfg_index=0.
  - i2c_start=0, i2c_data=0.
  - i2c_reset=1 for the whole time reset_n is low, and for 2 cycles after it deasserts.
  - Reset mid-transaction aborts immediately; no partial write is resumed.
- Internal state: byte_sel (0 = register byte, 1 = value byte); retry counter; timeout counter; gap counter.
- i2c_data = byte_sel ? cfg_val : cfg_reg (combinational from registered byte_sel and cfg_index).
- FSM states and transitions:
  - IDLE: on go=1, clear cfg_done, cfg_error and retry; cfg_index=0; busy=1; go to LOAD.
  - LOAD (1 cycle): byte_sel=0; clear the timeout counter; go to START.
  - START: i2c_start=1 for exactly 1 cycle; go to WAIT_REG.
  - WAIT_REG:
    - i2c_done=1: set byte_sel=1 on the same edge, clear the timeout counter, go to WAIT_VAL.
    - i2c_fail=1, or the timeout counter reaches TIMEOUT: go to RECOVER.
  - WAIT_VAL:
    - i2c_done=1: go to GAP.
    - i2c_fail=1 or timeout: go to RECOVER.
  - GAP: count STOP_GAP cycles, then go to ADVANCE.
  - ADVANCE:
    - cfg_index==NUM_WRITES-1: cfg_done=1, busy=0, go to IDLE.
    - Otherwise: cfg_index+1, retry=0, go to LOAD.
  - RECOVER: i2c_reset=1 for 2 cycles; this also clears the master's sticky fail.
    - retry<MAX_RETRIES: retry+1, go to LOAD with the same cfg_index.
    - Otherwise: cfg_error=1, err_index=cfg_index, busy=0, go to IDLE.
- Simultaneous i2c_done and i2c_fail in the same cycle: fail wins.
- i2c_done seen in any state other than WAIT_REG/WAIT_VAL is ignored.
- go while busy=1 is ignored; go in the same cycle cfg_done sets is also ignored.
- cfg_index does not wrap; the pass ends at NUM_WRITES-1.
- Counter widths: sized for TIMEOUT, STOP_GAP and MAX_RETRIES with no overflow. The timeout counter saturates.

Test Plan:
- Nominal pass:
  - Stimulus: NUM_WRITES=4; slave model acks every byte; pulse go.
  - Response: exactly 4 transactions, bytes {0x72,reg,val} per entry in index order; cfg_done=1 and busy=0 after the last STOP_GAP; cfg_error=0.
- Single NACK recovery:
  - Stimulus: slave NACKs the value byte of entry 2 once.
  - Response: i2c_reset pulses for 2 cycles; entry 2 is resent in full; the pass completes with cfg_done=1.
- Persistent NACK:
  - Stimulus: slave NACKs entry 1 always; MAX_RETRIES=3.
  - Response: 4 attempts on entry 1; cfg_error=1; err_index=1; no transaction for entry 2.
- Hung master:
  - Stimulus: hold i2c_done=0 after start.
  - Response: RECOVER after exactly TIMEOUT cycles, then retry.
- Reset mid-transaction:
  - Stimulus: drive reset_n=0 during WAIT_VAL of entry 3.
  - Response: all outputs at reset values next edge; i2c_reset held.
  - Then: a fresh go restarts from index 0.
- go while busy:
  - Stimulus: second go pulse during entry 1.
  - Response: no effect; cfg_index sequence unchanged.
